// File: rtl/ahb3lite_sram_arb2.sv
// Two-port AHB3-Lite arbiter sharing one single-port SRAM slave.
// Each port holds its request and reissues it downstream as NONSEQ.
module ahb3lite_sram_arb2 #(
  parameter int    HADDR_SIZE = 8,
  parameter int    HDATA_SIZE = 32,
  parameter string ARB_SCHEME = "RR"
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,

  input  logic                  p0_HSEL,
  input  logic [HADDR_SIZE-1:0] p0_HADDR,
  input  logic [HDATA_SIZE-1:0] p0_HWDATA,
  output logic [HDATA_SIZE-1:0] p0_HRDATA,
  input  logic                  p0_HWRITE,
  input  logic [2:0]            p0_HSIZE,
  input  logic [2:0]            p0_HBURST,
  input  logic [3:0]            p0_HPROT,
  input  logic [1:0]            p0_HTRANS,
  input  logic                  p0_HREADY,
  output logic                  p0_HREADYOUT,
  output logic                  p0_HRESP,

  input  logic                  p1_HSEL,
  input  logic [HADDR_SIZE-1:0] p1_HADDR,
  input  logic [HDATA_SIZE-1:0] p1_HWDATA,
  output logic [HDATA_SIZE-1:0] p1_HRDATA,
  input  logic                  p1_HWRITE,
  input  logic [2:0]            p1_HSIZE,
  input  logic [2:0]            p1_HBURST,
  input  logic [3:0]            p1_HPROT,
  input  logic [1:0]            p1_HTRANS,
  input  logic                  p1_HREADY,
  output logic                  p1_HREADYOUT,
  output logic                  p1_HRESP,

  output logic                  mem_HSEL,
  output logic [HADDR_SIZE-1:0] mem_HADDR,
  output logic [HDATA_SIZE-1:0] mem_HWDATA,
  input  logic [HDATA_SIZE-1:0] mem_HRDATA,
  output logic                  mem_HWRITE,
  output logic [2:0]            mem_HSIZE,
  output logic [2:0]            mem_HBURST,
  output logic [3:0]            mem_HPROT,
  output logic [1:0]            mem_HTRANS,
  input  logic                  mem_HREADYOUT,
  output logic                  mem_HREADY,
  input  logic                  mem_HRESP
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam bit         FIXED     = (ARB_SCHEME == "FIXED");

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DATA
  } st_t;

  st_t                   st_q    [2];
  logic [HADDR_SIZE-1:0] addr_q  [2];
  logic                  wr_q    [2];
  logic [2:0]            size_q  [2];
  logic [2:0]            burst_q [2];
  logic [3:0]            prot_q  [2];

  logic                  ptr_q;
  logic                  dp_valid_q;
  logic                  dp_owner_q;
  logic [HADDR_SIZE-1:0] maddr_q;
  logic                  mwr_q;
  logic [2:0]            msize_q;
  logic [2:0]            mburst_q;
  logic [3:0]            mprot_q;

  logic [1:0][HADDR_SIZE-1:0] in_addr;
  logic [1:0]                 in_wr;
  logic [1:0][2:0]            in_size;
  logic [1:0][2:0]            in_burst;
  logic [1:0][3:0]            in_prot;

  logic [1:0] req;
  logic [1:0] cap;
  logic [1:0] wt;
  logic [1:0] gnt;
  logic       issue;
  logic       win;

  assign in_addr  = {p1_HADDR, p0_HADDR};
  assign in_wr    = {p1_HWRITE, p0_HWRITE};
  assign in_size  = {p1_HSIZE, p0_HSIZE};
  assign in_burst = {p1_HBURST, p0_HBURST};
  assign in_prot  = {p1_HPROT, p0_HPROT};

  assign req[0] = p0_HSEL & p0_HREADY & p0_HTRANS[1];
  assign req[1] = p1_HSEL & p1_HREADY & p1_HTRANS[1];

  always_comb begin
    cap = '0;
    wt  = '0;
    for (int i = 0; i < 2; i++) begin
      wt[i]  = (st_q[i] == S_WAIT);
      cap[i] = req[i] & ((st_q[i] == S_IDLE) |
               ((st_q[i] == S_DATA) & mem_HREADYOUT));
    end
    gnt = wt;
    // ptr_q holds the last granted port; the other one wins a tie
    if (wt == 2'b11)
      gnt = (FIXED || ptr_q) ? 2'b01 : 2'b10;
  end

  assign issue = (|gnt) & mem_HREADYOUT;
  assign win   = gnt[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]    <= S_IDLE;
        addr_q[i]  <= '0;
        wr_q[i]    <= 1'b0;
        size_q[i]  <= '0;
        burst_q[i] <= '0;
        prot_q[i]  <= '0;
      end
      ptr_q      <= 1'b1;
      dp_valid_q <= 1'b0;
      dp_owner_q <= 1'b0;
      maddr_q    <= '0;
      mwr_q      <= 1'b0;
      msize_q    <= '0;
      mburst_q   <= '0;
      mprot_q    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        unique case (st_q[i])
          S_IDLE:
            if (req[i]) st_q[i] <= S_WAIT;
          S_WAIT:
            if (gnt[i] && mem_HREADYOUT) st_q[i] <= S_DATA;
          S_DATA:
            if (mem_HREADYOUT)
              st_q[i] <= req[i] ? S_WAIT : S_IDLE;
          default:
            st_q[i] <= S_IDLE;
        endcase
        if (cap[i]) begin
          addr_q[i]  <= in_addr[i];
          wr_q[i]    <= in_wr[i];
          size_q[i]  <= in_size[i];
          burst_q[i] <= in_burst[i];
          prot_q[i]  <= in_prot[i];
        end
      end
      if (issue) begin
        ptr_q      <= win;
        dp_valid_q <= 1'b1;
        dp_owner_q <= win;
        maddr_q    <= addr_q[win];
        mwr_q      <= wr_q[win];
        msize_q    <= size_q[win];
        mburst_q   <= burst_q[win];
        mprot_q    <= prot_q[win];
      end else if (mem_HREADYOUT) begin
        dp_valid_q <= 1'b0;
      end
    end
  end

  assign mem_HSEL   = issue;
  assign mem_HTRANS = issue ? HT_NONSEQ : HT_IDLE;
  assign mem_HADDR  = issue ? addr_q[win]  : maddr_q;
  assign mem_HWRITE = issue ? wr_q[win]    : mwr_q;
  assign mem_HSIZE  = issue ? size_q[win]  : msize_q;
  assign mem_HBURST = issue ? burst_q[win] : mburst_q;
  assign mem_HPROT  = issue ? prot_q[win]  : mprot_q;
  assign mem_HREADY = mem_HREADYOUT;

  assign mem_HWDATA = !dp_valid_q ? '0 :
                      dp_owner_q  ? p1_HWDATA : p0_HWDATA;

  assign p0_HREADYOUT = (st_q[0] == S_WAIT) ? 1'b0 :
                        (st_q[0] == S_DATA) ? mem_HREADYOUT : 1'b1;
  assign p1_HREADYOUT = (st_q[1] == S_WAIT) ? 1'b0 :
                        (st_q[1] == S_DATA) ? mem_HREADYOUT : 1'b1;

  assign p0_HRESP = (st_q[0] == S_DATA) & mem_HRESP;
  assign p1_HRESP = (st_q[1] == S_DATA) & mem_HRESP;

  assign p0_HRDATA = HRESETn ? mem_HRDATA : '0;
  assign p1_HRDATA = HRESETn ? mem_HRDATA : '0;

endmodule

// File: tb/tb_ahb3lite_sram_arb2.sv
// Directed bench for ahb3lite_sram_arb2 with a small SRAM model.
// A second FIXED-priority instance is used for grant order only.
module tb_ahb3lite_sram_arb2;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        p0_HSEL, p1_HSEL;
  logic [7:0]  p0_HADDR, p1_HADDR;
  logic [31:0] p0_HWDATA, p1_HWDATA;
  logic [31:0] p0_HRDATA, p1_HRDATA;
  logic        p0_HWRITE, p1_HWRITE;
  logic [2:0]  p0_HSIZE, p1_HSIZE;
  logic [2:0]  p0_HBURST, p1_HBURST;
  logic [3:0]  p0_HPROT, p1_HPROT;
  logic [1:0]  p0_HTRANS, p1_HTRANS;
  logic        p0_HREADY, p1_HREADY;
  logic        p0_HREADYOUT, p1_HREADYOUT;
  logic        p0_HRESP, p1_HRESP;

  logic        mem_HSEL, mem_HWRITE, mem_HREADYOUT, mem_HREADY, mem_HRESP;
  logic [7:0]  mem_HADDR;
  logic [31:0] mem_HWDATA, mem_HRDATA;
  logic [2:0]  mem_HSIZE, mem_HBURST;
  logic [3:0]  mem_HPROT;
  logic [1:0]  mem_HTRANS;

  logic [31:0] f_p0_HRDATA, f_p1_HRDATA, f_mem_HWDATA;
  logic        f_p0_HREADYOUT, f_p1_HREADYOUT, f_p0_HRESP, f_p1_HRESP;
  logic        f_p0_HREADY, f_p1_HREADY;
  logic        f_mem_HSEL, f_mem_HWRITE, f_mem_HREADY;
  logic [7:0]  f_mem_HADDR;
  logic [2:0]  f_mem_HSIZE, f_mem_HBURST;
  logic [3:0]  f_mem_HPROT;
  logic [1:0]  f_mem_HTRANS;

  logic stall = 1'b0;

  assign p0_HREADY     = p0_HREADYOUT;
  assign p1_HREADY     = p1_HREADYOUT;
  assign f_p0_HREADY   = f_p0_HREADYOUT;
  assign f_p1_HREADY   = f_p1_HREADYOUT;
  assign mem_HREADYOUT = ~stall;
  assign mem_HRESP     = 1'b0;

  ahb3lite_sram_arb2 #(.HADDR_SIZE(8), .HDATA_SIZE(32), .ARB_SCHEME("RR")) dut (
    .HRESETn(HRESETn), .HCLK(HCLK),
    .p0_HSEL(p0_HSEL), .p0_HADDR(p0_HADDR), .p0_HWDATA(p0_HWDATA),
    .p0_HRDATA(p0_HRDATA), .p0_HWRITE(p0_HWRITE), .p0_HSIZE(p0_HSIZE),
    .p0_HBURST(p0_HBURST), .p0_HPROT(p0_HPROT), .p0_HTRANS(p0_HTRANS),
    .p0_HREADY(p0_HREADY), .p0_HREADYOUT(p0_HREADYOUT), .p0_HRESP(p0_HRESP),
    .p1_HSEL(p1_HSEL), .p1_HADDR(p1_HADDR), .p1_HWDATA(p1_HWDATA),
    .p1_HRDATA(p1_HRDATA), .p1_HWRITE(p1_HWRITE), .p1_HSIZE(p1_HSIZE),
    .p1_HBURST(p1_HBURST), .p1_HPROT(p1_HPROT), .p1_HTRANS(p1_HTRANS),
    .p1_HREADY(p1_HREADY), .p1_HREADYOUT(p1_HREADYOUT), .p1_HRESP(p1_HRESP),
    .mem_HSEL(mem_HSEL), .mem_HADDR(mem_HADDR), .mem_HWDATA(mem_HWDATA),
    .mem_HRDATA(mem_HRDATA), .mem_HWRITE(mem_HWRITE), .mem_HSIZE(mem_HSIZE),
    .mem_HBURST(mem_HBURST), .mem_HPROT(mem_HPROT), .mem_HTRANS(mem_HTRANS),
    .mem_HREADYOUT(mem_HREADYOUT), .mem_HREADY(mem_HREADY),
    .mem_HRESP(mem_HRESP)
  );

  ahb3lite_sram_arb2 #(.HADDR_SIZE(8), .HDATA_SIZE(32), .ARB_SCHEME("FIXED")) dut_fx (
    .HRESETn(HRESETn), .HCLK(HCLK),
    .p0_HSEL(p0_HSEL), .p0_HADDR(p0_HADDR), .p0_HWDATA(p0_HWDATA),
    .p0_HRDATA(f_p0_HRDATA), .p0_HWRITE(p0_HWRITE), .p0_HSIZE(p0_HSIZE),
    .p0_HBURST(p0_HBURST), .p0_HPROT(p0_HPROT), .p0_HTRANS(p0_HTRANS),
    .p0_HREADY(f_p0_HREADY), .p0_HREADYOUT(f_p0_HREADYOUT),
    .p0_HRESP(f_p0_HRESP),
    .p1_HSEL(p1_HSEL), .p1_HADDR(p1_HADDR), .p1_HWDATA(p1_HWDATA),
    .p1_HRDATA(f_p1_HRDATA), .p1_HWRITE(p1_HWRITE), .p1_HSIZE(p1_HSIZE),
    .p1_HBURST(p1_HBURST), .p1_HPROT(p1_HPROT), .p1_HTRANS(p1_HTRANS),
    .p1_HREADY(f_p1_HREADY), .p1_HREADYOUT(f_p1_HREADYOUT),
    .p1_HRESP(f_p1_HRESP),
    .mem_HSEL(f_mem_HSEL), .mem_HADDR(f_mem_HADDR), .mem_HWDATA(f_mem_HWDATA),
    .mem_HRDATA(32'h0), .mem_HWRITE(f_mem_HWRITE), .mem_HSIZE(f_mem_HSIZE),
    .mem_HBURST(f_mem_HBURST), .mem_HPROT(f_mem_HPROT),
    .mem_HTRANS(f_mem_HTRANS), .mem_HREADYOUT(1'b1),
    .mem_HREADY(f_mem_HREADY), .mem_HRESP(1'b0)
  );

  // SRAM model: registered address phase, data phase served from the array
  logic [31:0] marr [64];
  logic        dv, dw;
  logic [7:0]  da;
  logic [2:0]  ds;
  logic        pl_en = 1'b0;
  logic [5:0]  pl_a = '0;
  logic [31:0] pl_d = '0;
  logic [3:0]  lanes;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dv <= 1'b0;
      dw <= 1'b0;
      da <= '0;
      ds <= '0;
    end else if (mem_HREADYOUT) begin
      dv <= mem_HSEL & mem_HTRANS[1];
      dw <= mem_HWRITE;
      da <= mem_HADDR;
      ds <= mem_HSIZE;
    end
  end

  always_comb begin
    lanes = 4'hF;
    if (ds == 3'd0) lanes = 4'b0001 << da[1:0];
    else if (ds == 3'd1) lanes = da[1] ? 4'b1100 : 4'b0011;
  end

  always @(posedge HCLK) begin
    if (pl_en) begin
      marr[pl_a] <= pl_d;
    end else if (dv && dw && mem_HREADYOUT) begin
      for (int b = 0; b < 4; b++)
        if (lanes[b]) marr[da[7:2]][8*b +: 8] <= mem_HWDATA[8*b +: 8];
    end
  end

  assign mem_HRDATA = (dv && !dw) ? marr[da[7:2]] : 32'h0;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] q_rr [$];
  logic [7:0] q_fx [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp;
    @(negedge HCLK);
  endtask

  task automatic idle_all;
    p0_HSEL = 1'b0; p0_HTRANS = 2'b00;
    p1_HSEL = 1'b0; p1_HTRANS = 2'b00;
  endtask

  task automatic rd0(input logic [7:0] a);
    p0_HSEL = 1'b1; p0_HTRANS = 2'b10; p0_HADDR = a;
    p0_HWRITE = 1'b0; p0_HSIZE = 3'd2;
  endtask

  task automatic rd1(input logic [7:0] a);
    p1_HSEL = 1'b1; p1_HTRANS = 2'b10; p1_HADDR = a;
    p1_HWRITE = 1'b0; p1_HSIZE = 3'd2;
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    nxt;
    pl_en = 1'b0;
  endtask

  task automatic rec;
    if (mem_HSEL) q_rr.push_back(mem_HADDR);
    if (f_mem_HSEL) q_fx.push_back(f_mem_HADDR);
  endtask

  task automatic round(input logic r0, input logic [7:0] a0,
                       input logic r1, input logic [7:0] a1);
    nxt;
    idle_all;
    if (r0) rd0(a0);
    if (r1) rd1(a1);
    smp; rec;
    repeat (3) begin
      nxt; idle_all; smp; rec;
    end
  endtask

  logic [7:0] e_rr [9];
  logic [7:0] e_fx [9];

  initial begin
    e_rr = '{8'h40, 8'h80, 8'h44, 8'h84, 8'h48, 8'h88, 8'h4C, 8'h90, 8'h50};
    e_fx = '{8'h40, 8'h80, 8'h44, 8'h84, 8'h48, 8'h88, 8'h4C, 8'h50, 8'h90};
    idle_all;
    p0_HADDR = '0; p1_HADDR = '0; p0_HWDATA = '0; p1_HWDATA = '0;
    p0_HWRITE = 1'b0; p1_HWRITE = 1'b0; p0_HSIZE = 3'd2; p1_HSIZE = 3'd2;
    p0_HBURST = '0; p1_HBURST = '0; p0_HPROT = 4'h3; p1_HPROT = 4'h3;

    // reset state
    preload(6'd4, 32'hCAFEBABE);
    preload(6'd12, 32'hAABBCCDD);
    smp;
    chk("rst_p0_ready", p0_HREADYOUT, 1);
    chk("rst_p1_ready", p1_HREADYOUT, 1);
    chk("rst_p0_resp", p0_HRESP, 0);
    chk("rst_p0_rdata", p0_HRDATA, 0);
    chk("rst_mem_sel", mem_HSEL, 0);
    chk("rst_mem_trans", mem_HTRANS, 0);
    chk("rst_mem_wdata", mem_HWDATA, 0);

    // single read from port 0
    nxt; HRESETn = 1'b1; rd0(8'h10);
    smp;
    chk("t1_T_ready", p0_HREADYOUT, 1);
    chk("t1_T_nosel", mem_HSEL, 0);
    nxt; idle_all;
    smp;
    chk("t1_T1_ready", p0_HREADYOUT, 0);
    chk("t1_T1_sel", mem_HSEL, 1);
    chk("t1_T1_trans", mem_HTRANS, 2'b10);
    chk("t1_T1_addr", mem_HADDR, 8'h10);
    nxt;
    smp;
    chk("t1_T2_ready", p0_HREADYOUT, 1);
    chk("t1_T2_rdata", p0_HRDATA, 32'hCAFEBABE);
    chk("t1_T2_nosel", mem_HSEL, 0);

    // simultaneous writes after a fresh reset
    nxt; HRESETn = 1'b0;
    nxt; HRESETn = 1'b1;
    nxt;
    p0_HSEL = 1'b1; p0_HTRANS = 2'b10; p0_HADDR = 8'h20;
    p0_HWRITE = 1'b1; p0_HSIZE = 3'd2;
    p1_HSEL = 1'b1; p1_HTRANS = 2'b10; p1_HADDR = 8'h24;
    p1_HWRITE = 1'b1; p1_HSIZE = 3'd2;
    smp;
    chk("t2_T_nosel", mem_HSEL, 0);
    nxt; idle_all;
    p0_HWDATA = 32'h11111111; p1_HWDATA = 32'h22222222;
    smp;
    chk("t2_T1_addr", mem_HADDR, 8'h20);
    chk("t2_T1_write", mem_HWRITE, 1);
    chk("t2_T1_p0rdy", p0_HREADYOUT, 0);
    chk("t2_T1_p1rdy", p1_HREADYOUT, 0);
    nxt;
    smp;
    chk("t2_T2_addr", mem_HADDR, 8'h24);
    chk("t2_T2_wdata", mem_HWDATA, 32'h11111111);
    chk("t2_T2_p0rdy", p0_HREADYOUT, 1);
    chk("t2_T2_p1rdy", p1_HREADYOUT, 0);
    nxt;
    smp;
    chk("t2_T3_nosel", mem_HSEL, 0);
    chk("t2_T3_wdata", mem_HWDATA, 32'h22222222);
    chk("t2_T3_p1rdy", p1_HREADYOUT, 1);
    nxt;
    smp;
    chk("t2_word20", marr[8], 32'h11111111);
    chk("t2_word24", marr[9], 32'h22222222);
    p0_HWRITE = 1'b0; p1_HWRITE = 1'b0;

    // grant order: three ties, one lone p0, then a tie
    q_rr.delete(); q_fx.delete();
    round(1'b1, 8'h40, 1'b1, 8'h80);
    round(1'b1, 8'h44, 1'b1, 8'h84);
    round(1'b1, 8'h48, 1'b1, 8'h88);
    round(1'b1, 8'h4C, 1'b0, 8'h00);
    round(1'b1, 8'h50, 1'b1, 8'h90);
    chk("t3_rr_count", q_rr.size(), 9);
    chk("t3_fx_count", q_fx.size(), 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t3_rr_%0d", i),
          (i < q_rr.size()) ? {24'h0, q_rr[i]} : 32'hFFFFFFFF,
          {24'h0, e_rr[i]});
      chk($sformatf("t3_fx_%0d", i),
          (i < q_fx.size()) ? {24'h0, q_fx[i]} : 32'hFFFFFFFF,
          {24'h0, e_fx[i]});
    end

    // byte write then read-back with one memory stall
    nxt;
    p0_HSEL = 1'b1; p0_HTRANS = 2'b10; p0_HADDR = 8'h30;
    p0_HWRITE = 1'b1; p0_HSIZE = 3'd0;
    smp;
    nxt;
    p0_HSEL = 1'b0; p0_HTRANS = 2'b00; p0_HWDATA = 32'h000000EE;
    rd1(8'h30);
    smp;
    chk("t4_T1_addr", mem_HADDR, 8'h30);
    chk("t4_T1_size", mem_HSIZE, 3'd0);
    nxt; idle_all; p0_HWRITE = 1'b0;
    smp;
    chk("t4_T2_sel", mem_HSEL, 1);
    chk("t4_T2_read", mem_HWRITE, 0);
    chk("t4_T2_wdata", mem_HWDATA, 32'h000000EE);
    chk("t4_T2_p0rdy", p0_HREADYOUT, 1);
    nxt; stall = 1'b1;
    smp;
    chk("t4_T3_p1rdy", p1_HREADYOUT, 0);
    chk("t4_T3_nosel", mem_HSEL, 0);
    nxt; stall = 1'b0;
    smp;
    chk("t4_T4_p1rdy", p1_HREADYOUT, 1);
    chk("t4_T4_rdata", p1_HRDATA, 32'hAABBCCEE);

    // p1 BUSY/IDLE while p0 is active
    nxt;
    rd0(8'h10);
    p1_HSEL = 1'b1; p1_HTRANS = 2'b01; p1_HADDR = 8'h60;
    smp;
    chk("t5_T_busy_rdy", p1_HREADYOUT, 1);
    chk("t5_T_busy_resp", p1_HRESP, 0);
    nxt;
    p0_HSEL = 1'b0; p0_HTRANS = 2'b00;
    p1_HSEL = 1'b1; p1_HTRANS = 2'b00; p1_HADDR = 8'h64;
    smp;
    chk("t5_T1_idle_rdy", p1_HREADYOUT, 1);
    chk("t5_T1_addr", mem_HADDR, 8'h10);
    nxt; idle_all;
    smp;
    chk("t5_T2_rdata", p0_HRDATA, 32'hCAFEBABE);
    chk("t5_T2_nosel", mem_HSEL, 0);
    nxt;
    smp;
    chk("t5_T3_nosel", mem_HSEL, 0);

    // reset while p0 waits and p1 sits in a stalled data phase
    nxt; rd1(8'h10);
    smp;
    nxt; idle_all; rd0(8'h24);
    smp;
    chk("t6_p1_issue", mem_HADDR, 8'h10);
    nxt; idle_all; stall = 1'b1;
    smp;
    chk("t6_p0_wait", p0_HREADYOUT, 0);
    chk("t6_p1_data", p1_HREADYOUT, 0);
    #1 HRESETn = 1'b0;
    #1;
    chk("t6_rst_p0rdy", p0_HREADYOUT, 1);
    chk("t6_rst_p1rdy", p1_HREADYOUT, 1);
    chk("t6_rst_p1resp", p1_HRESP, 0);
    chk("t6_rst_p1rdata", p1_HRDATA, 0);
    chk("t6_rst_sel", mem_HSEL, 0);
    chk("t6_rst_trans", mem_HTRANS, 0);
    chk("t6_rst_wdata", mem_HWDATA, 0);
    nxt; stall = 1'b0;
    nxt; HRESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt;
      smp;
      chk($sformatf("t6_post_nosel_%0d", i), mem_HSEL, 0);
      chk($sformatf("t6_post_p0rdy_%0d", i), p0_HREADYOUT, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb3lite_sram_arb2.md
Name: ahb3lite_sram_arb2

Overview:
- Two-port AHB3-Lite arbiter that shares one single-port AHB3-Lite SRAM slave between two masters.
- Each upstream port captures its master's address phase, arbitrates for the memory and reissues the transfer downstream as NONSEQ.
- The master stays stalled until the downstream data phase completes.
- Sits between the bus matrix and the SRAM; acts as the only master on the memory's AHB port.

Parameters:
HADDR_SIZE, 8, address bus width (upstream and downstream)
HDATA_SIZE, 32, data bus width
ARB_SCHEME, "RR", "RR" = round-robin, "FIXED" = port 0 always wins

Ports:
HRESETn  in  1  asynchronous active-low reset
HCLK  in  1  clock, rising edge
pN_HSEL  in  1  port N select (N = 0,1; every pN_ port exists for both)
pN_HADDR  in  HADDR_SIZE  port N address
pN_HWDATA  in  HDATA_SIZE  port N write data
pN_HRDATA  out  HDATA_SIZE  port N read data
pN_HWRITE  in  1  port N write
pN_HSIZE  in  3  port N size
pN_HBURST  in  3  port N burst
pN_HPROT  in  4  port N protection
pN_HTRANS  in  2  port N transfer type
pN_HREADY  in  1  port N bus ready
pN_HREADYOUT  out  1  port N slave ready
pN_HRESP  out  1  port N response
mem_HSEL  out  1  memory select
mem_HADDR  out  HADDR_SIZE  memory address
mem_HWDATA  out  HDATA_SIZE  memory write data
mem_HRDATA  in  HDATA_SIZE  memory read data
mem_HWRITE, mem_HSIZE, mem_HBURST, mem_HPROT, mem_HTRANS  out  1/3/3/4/2  memory control
mem_HREADYOUT  in  1  memory ready
mem_HREADY  out  1  driven as mem_HREADYOUT
mem_HRESP  in  1  memory response

Behaviour:
- Reset (async): both ports IDLE; pN_HREADYOUT=1; pN_HRESP=OKAY; pN_HRDATA=0; mem_HSEL=0; mem_HTRANS=IDLE; RR pointer=1, so port 0 wins first; data-phase-valid=0. Reset mid-transfer discards pending and in-flight transfers.
- Request N: pN_HSEL & pN_HREADY & pN_HTRANS in {NONSEQ,SEQ}. On a request, HADDR/HWRITE/HSIZE/HBURST/HPROT are registered into port N's holding register, and port N goes IDLE->WAIT.
- BUSY/IDLE or unselected transfers: zero-wait OKAY, no capture.
- Per-port FSM:
  - IDLE: HREADYOUT=1.
  - WAIT: HREADYOUT=0.
  - WAIT->DATA when port N is granted and mem_HREADYOUT=1, which is the downstream address-phase cycle.
  - DATA: HREADYOUT=mem_HREADYOUT, HRDATA=mem_HRDATA, HRESP=mem_HRESP.
  - DATA exits when mem_HREADYOUT=1. It goes to WAIT if a new request arrives that cycle, otherwise to IDLE.
- Arbitration:
  - Evaluated each cycle over ports in WAIT.
  - FIXED: port 0 wins.
  - RR: on a tie, the port not last granted wins. The pointer updates only on an issued address phase.
  - Per transfer only; bursts may interleave.
- Downstream address phase:
  - When a grant exists and mem_HREADYOUT=1: mem_HSEL=1, mem_HTRANS=NONSEQ, and address/control come from the winner's holding register.
  - Otherwise mem_HSEL=0 and mem_HTRANS=IDLE; address/control hold their last value.
- Downstream data phase: a registered owner (dp_owner, dp_valid) selects mem_HWDATA=pN_HWDATA. The master holds HWDATA stable while stalled in its data phase. With dp_valid=0, mem_HWDATA=0.
- Pipelining: one port's downstream data phase may overlap the other port's downstream address phase. Back-to-back issue is allowed.
- Non-owner port in IDLE sees HRESP=OKAY. HRDATA is don't-care but driven to mem_HRDATA.
- Latency (memory zero-wait): master address cycle T, downstream address T+1, downstream data T+2 with HREADYOUT=1. This gives exactly 1 wait state. A losing port adds 1 cycle per transfer ahead of it.
- A captured request is never issued downstream in its capture cycle.
- A memory stall (mem_HREADYOUT=0, e.g. partial-write contention) freezes all issue and extends the owner's data phase.

Test Plan:
- p0 read 0x10 alone, memory holds 0xCAFEBABE -> mem address phase at T+1 with NONSEQ; p0_HREADYOUT low at T+1, high at T+2; p0_HRDATA=0xCAFEBABE.
- p0 write 0x20 and p1 write 0x24 in the same cycle, RR after reset -> p0 issued at T+1, p1 at T+2; p1_HREADYOUT high at T+3; both words written; pointer=1.
- Three simultaneous request rounds, RR -> grant order 0,1,0,1,0,1. With ARB_SCHEME="FIXED", port 0 is always first.
- p0 byte write 0x30 then p1 word read 0x30 back-to-back; memory inserts one stall -> p1 data phase extended one cycle; p1_HRDATA returns the updated byte.
- p1 HTRANS=BUSY and IDLE while p0 is active -> p1_HREADYOUT=1, OKAY, no mem_HSEL for p1.
- Assert HRESETn=0 while p0 in WAIT and p1 in DATA -> all outputs immediately at reset values; no downstream transfer after release until a new request.
